// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle,
// WIDTH steps per operation, with the sign fix-up applied on the final step.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] raw_a;
  logic [AW-1:0]    acc;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [AW-1:0]    step_next;
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  // Operand magnitudes for signed ops, raw operands for unsigned ops
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    mag_a = a_neg ? (~a + WIDTH'(1)) : a;
    mag_b = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // One iteration step plus the final sign fix-up of the stepped accumulator
  always_comb begin
    mul_sum   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_trial = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb};
    div_ge    = div_trial >= {1'b0, opb};
    step_next = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      step_next = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ge};
    end
    prod     = neg_q ? (~step_next + AW'(1)) : step_next;
    div_zero = is_div && (opb == '0);
    res_hi   = prod[AW-1:WIDTH];
    res_lo   = prod[WIDTH-1:0];
    if (is_div) begin
      // Quotient and remainder carry independent signs
      res_lo = neg_q ? (~step_next[WIDTH-1:0] + WIDTH'(1)) : step_next[WIDTH-1:0];
      res_hi = neg_r ? (~step_next[AW-1:WIDTH] + WIDTH'(1)) : step_next[AW-1:WIDTH];
      if (div_zero) begin
        res_lo = '1;
        res_hi = raw_a;
      end
    end
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      raw_a  <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= op[1] & a_neg;
            opb    <= mag_b;
            raw_a  <= a;
            acc    <= {{WIDTH{1'b0}}, mag_a};
            cnt    <= '0;
            div0   <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            hi    <= res_hi;
            lo    <= res_lo;
            div0  <= div_zero;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued operations push expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          passed = 0;
  int          total = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic        prev_done = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference: plain 64-bit arithmetic, C-style truncating division
  function automatic exp_t model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      p;
    logic [63:0] up;
    e.div0 = 1'b0;
    e.due  = 0;
    e.hi   = '0;
    e.lo   = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'd0) begin
      p = sx * sy;
      {e.hi, e.lo} = 64'(p);
    end else if (o == 2'd1) begin
      up = {32'b0, x} * {32'b0, y};
      {e.hi, e.lo} = up;
    end else if (y == 32'd0) begin
      e.lo = '1;
      e.hi = x;
      e.div0 = 1'b1;
    end else if (o == 2'd2) begin
      e.lo = 32'(sx / sy);
      e.hi = 32'(sx % sy);
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_pulse", 64'(prev_done), 64'(0));
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_hi", 64'(hi), 64'(mon_e.hi));
        chk("result_lo", 64'(lo), 64'(mon_e.lo));
        chk("result_div0", 64'(div0), 64'(mon_e.div0));
        chk("done_latency", 64'(cyc), 64'(mon_e.due));
        chk("busy_low_at_done", 64'(busy), 64'(0));
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(1), 64'(0));
  endtask

  // Launch one operation; called and returns at a falling edge
  task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y, bit expect_result = 1'b1);
    exp_t e;
    wait_idle();
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom);
    chk("div0_cleared_on_start", 64'(div0), 64'(0));
    chk("busy_after_start", 64'(busy), 64'(1));
    if (expect_result) begin
      e = model(o, x, y);
      e.due = cyc + 32;
      sb_q.push_back(e);
      model_hi = e.hi;
      model_lo = e.lo;
    end
    @(negedge clk);
  endtask

  initial begin
    int          n;
    int          sel;
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_div0", 64'(div0), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // MULTU extremes with busy-length measurement
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'(32));
    chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    wait_idle();
    chk("mult_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000);
    wait_idle();
    chk("mult_min_hi", 64'(hi), 64'h0000_0000_4000_0000);
    chk("mult_min_lo", 64'(lo), 64'(0));
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    issue(2'd3, 32'd100, 32'd7);
    wait_idle();
    chk("divu_lo", 64'(lo), 64'(14));
    chk("divu_hi", 64'(hi), 64'(2));
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'(0));
    chk("div_ovf_div0", 64'(div0), 64'(0));
    issue(2'd3, 32'd5, 32'd0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("div0_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    chk("div0_hi", 64'(hi), 64'(5));
    chk("div0_sticky", 64'(div0), 64'(1));
    issue(2'd2, 32'hFFFF_FFF0, 32'd0);
    issue(2'd3, 32'd9, 32'd3);
    wait_idle();

    // start and MTHI during busy are both ignored
    issue(2'd1, 32'h0001_0003, 32'h0000_0101);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd77; b = 32'd99;
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_idle();
    chk("ignored_start_hi", 64'(hi), 64'(model_hi));
    chk("ignored_start_lo", 64'(lo), 64'(model_lo));

    // MTHI after done, then MTHI+MTLO together
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo_unchanged", 64'(lo), 64'(model_lo));
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_both_hi", 64'(hi), 64'hCAFE_0001);
    chk("mtlo_both_lo", 64'(lo), 64'hCAFE_0001);
    @(negedge clk);

    // MTHI in the same edge as start lands, then is overwritten by the result
    hi_we = 1'b1; wdata = 32'h0BAD_BEEF;
    issue(2'd1, 32'd6, 32'd7);
    hi_we = 1'b0;
    chk("mthi_with_start", 64'(hi), 64'h0BAD_BEEF);
    wait_idle();

    // Reset mid-operation: nothing committed, no done afterwards
    issue(2'd1, 32'd3, 32'd5, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_busy", 64'(busy), 64'(0));
    chk("midreset_hi", 64'(hi), 64'(0));
    chk("midreset_lo", 64'(lo), 64'(0));
    chk("midreset_done", 64'(done), 64'(0));
    repeat (40) @(negedge clk);
    chk("midreset_still_idle", 64'(busy), 64'(0));
    issue(2'd1, 32'd3, 32'd5);
    wait_idle();
    chk("after_reset_lo", 64'(lo), 64'(15));
    chk("after_reset_hi", 64'(hi), 64'(0));

    // Randomized operations, back-to-back and with idle MTHI/MTLO gaps
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = '0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) begin x = 32'($urandom_range(0, 20)) - 32'd10; y = 32'($urandom_range(1, 7)); end
      else if (sel == 3) y = 32'($urandom_range(0, 3)) - 32'd2;
      issue(o, x, y);
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        hi_we = 1'($urandom);
        lo_we = 1'($urandom);
        wdata = $urandom;
        @(posedge clk);
        #1;
        if (hi_we) model_hi = wdata;
        if (lo_we) model_lo = wdata;
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("rand_mt_hi", 64'(hi), 64'(model_hi));
        chk("rand_mt_lo", 64'(lo), 64'(model_lo));
        @(negedge clk);
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the multicycle MIPS datapath.
- Sits directly downstream of the register file. Consumes the rs/rt read data (rd1/rd2) for MULT/MULTU/DIV/DIVU.
- Also takes MTHI/MTLO writes and supplies HI/LO to the writeback mux for MFHI/MFLO.
- Controller stalls on busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; also the iteration count per operation.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  launch operation; sampled only when idle
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- a  input  WIDTH  rs operand (regfile rd1); multiplicand or dividend
- b  input  WIDTH  rt operand (regfile rd2); multiplier or divisor
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data (rs)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result committed to HI/LO
- div0  output  1  last DIV/DIVU had divisor 0; sticky until next start
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, rst high at rising edge): state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, iteration counter=0. Overrides everything, including mid-operation; no partial result is committed and no done pulse follows.
- States: IDLE, RUN.
- IDLE to RUN, at the edge E0 where start=1:
  - Latch op.
  - Latch |a| and |b| as unsigned magnitudes for MULT/DIV; raw a, b for MULTU/DIVU.
  - Latch result sign flags.
  - Clear the accumulator and counter; clear div0.
  - busy=1 after E0.
- RUN: one radix-2 step per edge, at E1..E32 (WIDTH steps).
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
- At E32: apply sign fix-up, write HI/LO, set busy=0, set done=1 for exactly one cycle (cleared at E33), return to IDLE.
- Latency: done is high in the 32nd cycle after the start edge, and HI/LO hold the new values in that same cycle.
- Multiply result: 64-bit product, HI=bits[63:32], LO=bits[31:0].
  - MULT: product negated when the operand signs differ.
- Divide result: LO=quotient, HI=remainder.
  - DIV: quotient negative if the operand signs differ; remainder takes the sign of the dividend; magnitudes are truncated toward zero.
- DIV overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude algorithm; no special case.
- Divide by zero (b=0, DIV or DIVU): still takes 32 cycles. Result LO=0xFFFFFFFF, HI=a (original signed/raw value). div0=1 from E32 until the next accepted start or reset.
- start while busy: ignored, no queueing. start in the same cycle as done is accepted (state is IDLE).
- MTHI/MTLO:
  - In IDLE: hi_we/lo_we write wdata into HI/LO at the next edge. Both may be asserted together.
  - While busy: ignored.
  - In the same edge as start in IDLE: the write occurs, and the launched operation later overwrites HI/LO.
- a and b may change after E0 without affecting the result. hi/lo are stable during RUN (previous values).

Test Plan:
- Latency and MULTU extremes: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start 1 cycle → busy high 32 cycles; done single pulse 32 cycles after start edge; HI=0xFFFFFFFE, LO=0x00000001.
- MULT signed: a=0xFFFFFFFD (-3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT a=0x80000000, b=0x80000000 → HI=0x40000000, LO=0.
- DIV and DIVU: DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 → LO=14, HI=2.
- Corner divides:
  - DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0, div0=0.
  - DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5, div0=1.
  - The next start clears div0.
- Protocol: start again at cycle 5 of an operation, and pulse hi_we=1 (wdata=0x1234) during busy → both ignored; results match a single operation. After done, hi_we=1, wdata=0x1234 → HI=0x1234 next edge, LO unchanged.
- Reset mid-operation: MULTU 3×5, rst=1 at cycle 10 → busy=0, hi=lo=0 after that edge; no done pulse ever. Next MULTU 3×5 → LO=15, HI=0, done after 32 cycles.
